event_out_buffer: RTL and testbench
===================================

Name: event_out_buffer

Overview:
- Downstream stage of the event filter.
- Captures each filtered event (x, y, t, p; 2 bits each) and drops events the filter zeroed out.
- Queues survivors in a small synchronous FIFO and presents them as an 8-bit packed word on a valid/ready interface to the output pins/serializer.
- Counts events lost to overflow.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DROP_ZERO, 1, when 1, an input with {x,y,t}==0 is discarded as a filter reject; when 0, all valid inputs are queued.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  1  event present on x_in/y_in/t_in/p_in this cycle.
- x_in  in  2  event x from filter.
- y_in  in  2  event y from filter.
- t_in  in  2  event t from filter.
- p_in  in  2  event polarity from filter.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head this cycle.
- out_data  out  8  packed head event {x,y,t,p}, x in [7:6], p in [1:0].
- level  out  log2(DEPTH)+1  current occupancy.
- full  out  1  level==DEPTH.
- drop_cnt  out  CNT_W  events lost to overflow, saturating.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state (rst high at a clk edge):
  - Write and read pointers = 0, level = 0, drop_cnt = 0.
  - out_valid = 0, full = 0, out_data = 0.
  - Storage contents are don't-care but never visible while empty.
- Reset mid-operation discards all queued entries. in_valid and out_ready are ignored in the reset cycle.
- Accept condition: push = in_valid & ~(DROP_ZERO & {x_in,y_in,t_in}==0). p_in does not participate in the zero test.
- Pop condition: pop = out_valid & out_ready.
- Write rule: the entry is written when push & (~full | pop). A simultaneous push and pop when full is legal, level stays DEPTH.
- Overflow: push & full & ~pop drops the event. drop_cnt increments by 1, saturating at 2^CNT_W-1. Queue contents are unchanged.
- Latency: an event written at edge N is visible on out_valid/out_data after edge N (first cycle N+1). There is no same-cycle bypass when empty.
- out_valid = (level != 0). out_data = storage[rd_ptr] when out_valid, else 0.
- Once out_valid is asserted, out_data stays stable until popped; the consumer may hold out_ready low indefinitely.
- Pointers: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0.
- Level update:
  - +1 on write-only.
  - -1 on pop-only.
  - Unchanged on write+pop.
  - Unchanged on a dropped event.
- Event order is strictly FIFO. No entry is lost or duplicated except by the overflow rule.
- Filtered (zero) events never affect level or drop_cnt.

Decomposition:
- Shared package event_pkg:
  - Field width constant EV_FIELD_W = 2.
  - Packed width EV_W = 8.
  - Bit-position constants for x/y/t/p in the packed word.
  - Packed event typedef, reused by the filter and this buffer.
- Sub-module event_fifo: generic synchronous FIFO (DEPTH, WIDTH) providing push/pop/level/full.
- event_out_buffer adds zero-drop qualification, packing and the drop counter around it.

Test Plan:
- Reset then single event x=1,y=2,t=3,p=1, out_ready=1 -> out_valid high one cycle later with out_data=8'b01_10_11_01, popped, level returns 0.
- in_valid with x=y=t=0,p=1 (DROP_ZERO=1) -> nothing queued, level=0, drop_cnt=0. Same with DROP_ZERO=0 -> queued, out_data=8'h01.
- out_ready=0, push 6 distinct events into DEPTH=4 -> full=1, level=4, drop_cnt=2. Then drain -> first four events emerge in order, last two absent.
- Full with push and pop in same cycle -> level stays 4, head advances, new event appended at tail, drop_cnt unchanged.
- Push 300 events while full and out_ready=0 (CNT_W=8) -> drop_cnt saturates at 255.
- Fill to level 3, assert rst for one cycle while in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, drop_cnt=0, out_data=0.

Source files
------------

// File: rtl/event_pkg.sv
// Shared event definitions for the filter and output-buffer stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package event_pkg;

  localparam int EV_FIELD_W = 2;
  localparam int EV_W       = 4 * EV_FIELD_W;

  // Field LSB positions inside the packed 8-bit word {x,y,t,p}
  localparam int EV_X_LSB = 6;
  localparam int EV_Y_LSB = 4;
  localparam int EV_T_LSB = 2;
  localparam int EV_P_LSB = 0;

  // Packed event; declaration order places x in the MSBs and p in the LSBs
  typedef struct packed {
    logic [EV_FIELD_W-1:0] x;
    logic [EV_FIELD_W-1:0] y;
    logic [EV_FIELD_W-1:0] t;
    logic [EV_FIELD_W-1:0] p;
  } event_t;

  // The filter signals a reject by zeroing the coordinates; polarity is ignored
  function automatic logic ev_is_reject(input event_t e);
    return {e.x, e.y, e.t} == '0;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Generic synchronous FIFO with occupancy and full flags.
// Latency: a write at edge N is visible at the head from cycle N+1; no bypass.
// Backpressure: writes while full are refused unless a pop happens in the same cycle.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_wr;

  assign head_vld = (level != '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign do_pop   = pop & head_vld;
  // A full queue still takes a write when the head leaves in the same cycle
  assign do_wr    = push & (~full | do_pop);
  assign head_dat = head_vld ? mem[rd_ptr] : '0;

  // Storage write; contents need no reset since they are masked while empty
  always_ff @(posedge clk) begin
    if (!rst && do_wr) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/event_out_buffer.sv
// Output buffer: drops filter rejects, queues survivors, counts overflow losses.
// Latency: accepted event appears on out_valid/out_data one cycle after its write edge.
// Backpressure: out_ready may stall forever; events arriving while full and not draining are dropped and counted.
module event_out_buffer
  import event_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DROP_ZERO = 1,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [EV_FIELD_W-1:0]  x_in,
  input  logic [EV_FIELD_W-1:0]  y_in,
  input  logic [EV_FIELD_W-1:0]  t_in,
  input  logic [EV_FIELD_W-1:0]  p_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EV_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic [CNT_W-1:0]       drop_cnt
);

  event_t ev;
  logic   reject;
  logic   push;
  logic   pop;
  logic   drop;

  assign ev     = '{x: x_in, y: y_in, t: t_in, p: p_in};
  assign reject = (DROP_ZERO != 0) && ev_is_reject(ev);
  assign push   = in_valid & ~reject;
  assign pop    = out_valid & out_ready;
  assign drop   = push & full & ~pop;

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (ev),
    .pop      (pop),
    .head_vld (out_valid),
    .head_dat (out_data),
    .level    (level),
    .full     (full)
  );

  // Saturating count of events lost because the queue was full and stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_event_out_buffer.sv
// Self-checking bench: two buffers (zero-drop on and off) against a queue model.
// Latency: model updates at each rising edge; outputs sampled 1 time unit later.
// Backpressure: exercised by directed stalls and random out_ready.
module tb_event_out_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [1:0]       x_in = '0, y_in = '0, t_in = '0, p_in = '0;
  logic             out_ready = 1'b0;

  logic             v1, v0;
  logic [7:0]       d1, d0;
  logic [LW-1:0]    l1, l0;
  logic             f1, f0;
  logic [CNT_W-1:0] c1, c0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one queue and drop count per instance
  logic [7:0] q1[$];
  logic [7:0] q0[$];
  int         m1 = 0;
  int         m0 = 0;

  always #5 clk = ~clk;

  event_out_buffer #(.DEPTH(DEPTH), .DROP_ZERO(1), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x_in(x_in), .y_in(y_in), .t_in(t_in), .p_in(p_in),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .level(l1), .full(f1), .drop_cnt(c1)
  );

  event_out_buffer #(.DEPTH(DEPTH), .DROP_ZERO(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .x_in(x_in), .y_in(y_in), .t_in(t_in), .p_in(p_in),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0),
    .level(l0), .full(f0), .drop_cnt(c0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_ev(input logic vld, input logic [7:0] w);
    in_valid = vld;
    x_in = w[7:6];
    y_in = w[5:4];
    t_in = w[3:2];
    p_in = w[1:0];
  endtask

  // Behavioural reference: plain queue semantics applied to the inputs seen at the edge
  task automatic model_step();
    logic [7:0] w;
    logic       acc1, pop1, full1, pop0, full0;
    if (rst) begin
      q1.delete(); q0.delete();
      m1 = 0; m0 = 0;
      return;
    end
    w     = {x_in, y_in, t_in, p_in};
    acc1  = in_valid && (w[7:2] != 6'd0);
    full1 = (q1.size() == DEPTH);
    pop1  = (q1.size() != 0) && out_ready;
    full0 = (q0.size() == DEPTH);
    pop0  = (q0.size() != 0) && out_ready;
    if (pop1) void'(q1.pop_front());
    if (pop0) void'(q0.pop_front());
    if (acc1) begin
      if (full1 && !pop1) begin
        if (m1 < CMAX) m1++;
      end else begin
        q1.push_back(w);
      end
    end
    if (in_valid) begin
      if (full0 && !pop0) begin
        if (m0 < CMAX) m0++;
      end else begin
        q0.push_back(w);
      end
    end
  endtask

  task automatic check_all();
    chk("z_valid", 32'(v1), 32'(q1.size() != 0));
    chk("z_data",  32'(d1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
    chk("z_level", 32'(l1), 32'(q1.size()));
    chk("z_full",  32'(f1), 32'(q1.size() == DEPTH));
    chk("z_drop",  32'(c1), 32'(m1));
    chk("n_valid", 32'(v0), 32'(q0.size() != 0));
    chk("n_data",  32'(d0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
    chk("n_level", 32'(l0), 32'(q0.size()));
    chk("n_full",  32'(f0), 32'(q0.size() == DEPTH));
    chk("n_drop",  32'(c0), 32'(m0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  logic [7:0] vals [6];

  initial begin
    // Reset with live inputs, which must be ignored
    rst = 1'b1; out_ready = 1'b1;
    set_ev(1'b1, 8'hFF);
    tick(); tick();
    chk("rst_valid", 32'(v1), 32'd0);
    chk("rst_data",  32'(d1), 32'd0);
    chk("rst_level", 32'(l1), 32'd0);
    chk("rst_drop",  32'(c1), 32'd0);
    rst = 1'b0;
    set_ev(1'b0, 8'h00);
    tick();

    // Single event x=1,y=2,t=3,p=1
    set_ev(1'b1, 8'b01_10_11_01);
    tick();
    chk("single_valid", 32'(v1), 32'd1);
    chk("single_data",  32'(d1), 32'h6D);
    set_ev(1'b0, 8'h00);
    tick();
    chk("single_drain", 32'(l1), 32'd0);

    // Zero-coordinate event: rejected with DROP_ZERO=1, kept with DROP_ZERO=0
    set_ev(1'b1, 8'h01);
    tick();
    chk("zero_lvl_z",  32'(l1), 32'd0);
    chk("zero_drop_z", 32'(c1), 32'd0);
    chk("zero_data_n", 32'(d0), 32'h01);
    set_ev(1'b0, 8'h00);
    tick();

    // Six distinct events into a stalled queue
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vals[i] = 8'(((i + 1) << 2) | (i & 3));
      set_ev(1'b1, vals[i]);
      tick();
    end
    set_ev(1'b0, 8'h00);
    chk("ovf_full",  32'(f1), 32'd1);
    chk("ovf_level", 32'(l1), 32'd4);
    chk("ovf_drop",  32'(c1), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", 32'(d1), 32'(vals[i]));
      tick();
    end
    chk("drain_empty", 32'(l1), 32'd0);

    // Full queue with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_ev(1'b1, vals[i]);
      tick();
    end
    out_ready = 1'b1;
    set_ev(1'b1, 8'hE6);
    tick();
    chk("pp_level", 32'(l1), 32'd4);
    chk("pp_head",  32'(d1), 32'(vals[1]));
    chk("pp_drop",  32'(c1), 32'd2);

    // Saturation of the drop counter
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_ev(1'b1, 8'(($urandom_range(1, 63) << 2) | $urandom_range(0, 3)));
      tick();
    end
    chk("sat_drop", 32'(c1), 32'd255);
    chk("sat_full", 32'(f1), 32'd1);

    // Drain, fill to three, then reset mid-operation
    set_ev(1'b0, 8'h00);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_ev(1'b1, vals[i + 2]);
      tick();
    end
    chk("pre_rst_level", 32'(l1), 32'd3);
    rst = 1'b1; out_ready = 1'b1;
    set_ev(1'b1, 8'h9A);
    tick();
    chk("mid_rst_level", 32'(l1), 32'd0);
    chk("mid_rst_valid", 32'(v1), 32'd0);
    chk("mid_rst_drop",  32'(c1), 32'd0);
    chk("mid_rst_data",  32'(d1), 32'd0);
    rst = 1'b0;

    // Random traffic with alternating stall-heavy and drain-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if ($urandom_range(0, 5) == 0) w[7:2] = 6'd0;
      set_ev($urandom_range(0, 3) != 0, w);
      if (((i / 150) % 2) == 0) out_ready = ($urandom_range(0, 3) == 0);
      else                      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
